// File: rtl/vdp_io_ctrl.sv
// vdp_io_ctrl: Z80 port 0xBE/0xBF sequencer for the VDP.
// Decodes the two-byte control protocol, owns the auto-incrementing VRAM
// address, the access code, the read-ahead buffer and registers R0..R(N-1),
// and schedules one CPU VRAM access at a time into renderer free slots.
//
// VRAM handshake: vram_req is raised with vram_we/vram_addr/vram_wdata and
// all four are held stable until a cycle where vram_gnt is also high; that
// cycle is the transfer. vram_gnt while vram_req is low means nothing.
// For reads, vram_rdata is taken the cycle after the transfer.
module vdp_io_ctrl #(
    parameter int NUM_REGS = 11
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  io_wr,
    input  logic                  io_rd,
    input  logic                  port_ctrl,
    input  logic [7:0]            cpu_din,
    output logic [7:0]            cpu_dout,
    input  logic [7:0]            status_in,
    output logic                  status_clr,
    output logic                  busy,
    output logic                  ovf,
    output logic                  vram_req,
    output logic                  vram_we,
    output logic [13:0]           vram_addr,
    output logic [7:0]            vram_wdata,
    input  logic                  vram_gnt,
    input  logic [7:0]            vram_rdata,
    output logic                  cram_we,
    output logic [4:0]            cram_addr,
    output logic [7:0]            cram_wdata,
    output logic [8*NUM_REGS-1:0] regs
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_REQ   = 2'd1,
        ST_RDATA = 2'd2
    } state_t;

    state_t      state_q;
    state_t      state_d;

    logic        first;
    logic [7:0]  latch;
    logic [13:0] addr;
    logic [1:0]  code;
    logic [7:0]  rd_buf;
    logic        req_we;

    logic        ctrl_wr;
    logic        ctrl_rd;
    logic        data_wr;
    logic        data_rd;
    logic        ra_ctrl;
    logic        start_rd;
    logic        start_wr;
    logic        drop;
    logic [13:0] start_addr;
    logic        xfer;

    // Strobe decode and request scheduling; anything needing VRAM while busy is dropped
    always_comb begin
        ctrl_wr    = io_wr & port_ctrl;
        ctrl_rd    = io_rd & port_ctrl;
        data_wr    = io_wr & ~port_ctrl;
        data_rd    = io_rd & ~port_ctrl;
        ra_ctrl    = ctrl_wr & first & (cpu_din[7:6] == 2'b00);
        start_rd   = ~busy & (ra_ctrl | data_rd);
        start_wr   = ~busy & data_wr & (code != 2'b11);
        drop       = busy & (data_wr | data_rd | ra_ctrl);
        start_addr = ra_ctrl ? {cpu_din[5:0], latch} : addr;
        xfer       = vram_req & vram_gnt;
    end

    // CPU read mux: status on the control port, read-ahead buffer on the data port
    assign cpu_dout = port_ctrl ? status_in : rd_buf;

    // FSM state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next state: a write completes on grant, a read spends one cycle capturing data
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: begin
                if (start_rd || start_wr) begin
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                if (vram_gnt) begin
                    state_d = req_we ? ST_IDLE : ST_RDATA;
                end
            end
            ST_RDATA: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM outputs
    always_comb begin
        vram_req = (state_q == ST_REQ);
        busy     = (state_q != ST_IDLE);
        vram_we  = (state_q == ST_REQ) & req_we;
    end

    // Port protocol, address counter, read-ahead buffer, CRAM strobe and register file
    always_ff @(posedge clk) begin
        if (reset) begin
            first      <= 1'b0;
            latch      <= 8'h00;
            addr       <= 14'h0000;
            code       <= 2'b00;
            rd_buf     <= 8'h00;
            req_we     <= 1'b0;
            vram_addr  <= 14'h0000;
            vram_wdata <= 8'h00;
            ovf        <= 1'b0;
            status_clr <= 1'b0;
            cram_we    <= 1'b0;
            cram_addr  <= 5'd0;
            cram_wdata <= 8'h00;
            regs       <= '0;
        end else begin
            status_clr <= ctrl_rd;
            cram_we    <= 1'b0;

            if (drop) begin
                ovf <= 1'b1;
            end

            // The pending request keeps its own copy of address and data
            if (start_rd || start_wr) begin
                req_we     <= start_wr;
                vram_addr  <= start_addr;
                vram_wdata <= cpu_din;
            end

            // Auto-increment after a completed transfer; a same-cycle address load wins below
            if (xfer) begin
                addr <= addr + 14'd1;
            end

            if (state_q == ST_RDATA) begin
                rd_buf <= vram_rdata;
            end

            if (ctrl_wr) begin
                if (!first) begin
                    latch <= cpu_din;
                    first <= 1'b1;
                end else begin
                    first <= 1'b0;
                    code  <= cpu_din[7:6];
                    addr  <= {cpu_din[5:0], latch};
                    if (cpu_din[7:6] == 2'b10) begin
                        for (int i = 0; i < NUM_REGS; i++) begin
                            if (cpu_din[3:0] == 4'(i)) begin
                                regs[i*8 +: 8] <= latch;
                            end
                        end
                    end
                end
            end

            if (ctrl_rd || data_rd) begin
                first <= 1'b0;
            end

            // Data write: CRAM completes immediately, VRAM goes through the request path
            if (data_wr) begin
                first <= 1'b0;
                if (!busy) begin
                    rd_buf <= cpu_din;
                    if (code == 2'b11) begin
                        cram_we    <= 1'b1;
                        cram_addr  <= addr[4:0];
                        cram_wdata <= cpu_din;
                        addr       <= addr + 14'd1;
                    end
                end
            end
        end
    end

endmodule
